systolic_ctrl: RTL and testbench

Sequencer for an N x N output-stationary systolic array of multiply-accumulate PEs.
- On start: clears the PE accumulators, then streams k_len operand vectors from the A/B operand buffers into the array edges with diagonal skew.
- Flushes the pipeline, then pulses done once every PE sum_out holds the final dot product.
- Sits between the operand buffers / host control and the array's left/up edge inputs.

---
 rtl/systolic_ctrl_pkg.sv | 27 ++
 rtl/systolic_ctrl_if.sv | 47 ++++
 rtl/systolic_ctrl_skew.sv | 43 ++++
 rtl/systolic_ctrl.sv | 142 ++++++++++++++
 tb/tb_systolic_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_ctrl_pkg.sv
// systolic_pkg: shared types and defaults for the systolic array sequencer.
//   state_e       : sequencer FSM states
//   N_DEF/DW_DEF  : default array dimension and operand width
//   K_W_DEF       : default k_len / read address width
//   FLUSH_CYCLES  : drain time of the default array (2N-1)
//   flush_cycles(): drain time for an arbitrary N
package systolic_pkg;

    localparam int N_DEF        = 4;
    localparam int DW_DEF       = 8;
    localparam int K_W_DEF      = 8;
    localparam int FLUSH_CYCLES = 2 * N_DEF - 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Cycles for the last element to travel from PE(0,0) to PE(N-1,N-1).
    function automatic int flush_cycles(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// systolic_ctrl_if: host/buffer/array bundle around the sequencer.
//   master : host + operand buffer + array side (drives start, k_len, a_col, b_row)
//   slave  : sequencer side (drives busy, done, rd_en, rd_addr, left_vec, up_vec,
//            pe_clr and, with SYSTOLIC_CTRL_PERF_EN, perf_cycles)
// Optional macro: SYSTOLIC_CTRL_PERF_EN adds perf_cycles.
interface systolic_ctrl_if
    import systolic_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int DATA_WIDTH = DW_DEF,
    parameter int K_W        = K_W_DEF
) ();

    logic                             start;
    logic [K_W-1:0]                   k_len;
    logic                             busy;
    logic                             done;
    logic                             rd_en;
    logic [K_W-1:0]                   rd_addr;
    logic [N-1:0][DATA_WIDTH-1:0]     a_col;
    logic [N-1:0][DATA_WIDTH-1:0]     b_row;
    logic [N-1:0][DATA_WIDTH-1:0]     left_vec;
    logic [N-1:0][DATA_WIDTH-1:0]     up_vec;
    logic                             pe_clr;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]                      perf_cycles;

    modport master (
        output start, k_len, a_col, b_row,
        input  busy, done, rd_en, rd_addr, left_vec, up_vec, pe_clr, perf_cycles
    );
    modport slave (
        input  start, k_len, a_col, b_row,
        output busy, done, rd_en, rd_addr, left_vec, up_vec, pe_clr, perf_cycles
    );
`else
    modport master (
        output start, k_len, a_col, b_row,
        input  busy, done, rd_en, rd_addr, left_vec, up_vec, pe_clr
    );
    modport slave (
        input  start, k_len, a_col, b_row,
        output busy, done, rd_en, rd_addr, left_vec, up_vec, pe_clr
    );
`endif

endinterface

// File: rtl/systolic_ctrl_skew.sv
// skew_line: DEPTH-stage delay for one operand lane with a valid bit per stage.
//   clk, rst : clock, asynchronous active-high reset
//   data_i   : lane data from the operand buffer
//   vld_i    : data_i is a real operand this cycle
//   data_o   : data_i delayed DEPTH cycles, forced to 0 when its valid bit is 0
// DEPTH=0 is a gated wire-through.
module skew_line #(
    parameter int DEPTH      = 0,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  vld_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign data_o = vld_i ? data_i : '0;
        end else begin : g_pipe
            logic [DEPTH-1:0]                 vld_pipe;
            logic [DEPTH-1:0][DATA_WIDTH-1:0] dat_pipe;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_pipe <= '0;
                    dat_pipe <= '0;
                end else begin
                    vld_pipe[0] <= vld_i;
                    dat_pipe[0] <= data_i;
                    for (int s = 1; s < DEPTH; s++) begin
                        vld_pipe[s] <= vld_pipe[s-1];
                        dat_pipe[s] <= dat_pipe[s-1];
                    end
                end
            end

            assign data_o = vld_pipe[DEPTH-1] ? dat_pipe[DEPTH-1] : '0;
        end
    endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for an N x N output-stationary systolic MAC array.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : systolic_ctrl_if.slave
//     start/k_len      : host request, k_len sampled on acceptance in IDLE
//     busy/done        : busy CLEAR..FLUSH, done one-cycle pulse
//     rd_en/rd_addr    : operand buffer read, data returns one cycle later on a_col/b_row
//     left_vec/up_vec  : diagonally skewed lanes into the array edges
//     pe_clr           : accumulator clear during CLEAR
//     perf_cycles      : busy cycles of the last operation (SYSTOLIC_CTRL_PERF_EN only)
// Optional macro: SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int DATA_WIDTH = DW_DEF,
    parameter int K_W        = K_W_DEF
) (
    input  logic      clk,
    input  logic      rst,
    systolic_ctrl_if.slave bus
);

    localparam int FL   = flush_cycles(N);
    localparam int FC_W = (FL > 1) ? $clog2(FL) : 1;

    state_e          state_q, state_d;
    logic [K_W-1:0]  k_len_q;
    logic [K_W-1:0]  cnt_q;
    logic [FC_W-1:0] fl_q;
    logic            vld_q;

    logic            busy_w, done_w, rd_en_w, pe_clr_w;
    logic [K_W-1:0]  rd_addr_w;
    logic            feed_last, flush_last, accept;

    assign feed_last  = (cnt_q == k_len_q - K_W'(1));
    assign flush_last = (fl_q == FC_W'(FL - 1));
    assign accept     = (state_q == IDLE) && bus.start;

    // ---- state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CLEAR;
            CLEAR:   state_d = (k_len_q == '0) ? DONE : FEED;
            FEED:    if (feed_last) state_d = FLUSH;
            FLUSH:   if (flush_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- outputs
    always_comb begin
        busy_w    = 1'b0;
        done_w    = 1'b0;
        rd_en_w   = 1'b0;
        pe_clr_w  = 1'b0;
        rd_addr_w = '0;
        case (state_q)
            CLEAR: begin
                busy_w   = 1'b1;
                pe_clr_w = 1'b1;
            end
            FEED: begin
                busy_w    = 1'b1;
                rd_en_w   = 1'b1;
                rd_addr_w = cnt_q;
            end
            FLUSH:   busy_w = 1'b1;
            DONE:    done_w = 1'b1;
            default: ;
        endcase
    end

    // ---- counters and read-data valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_len_q <= '0;
            cnt_q   <= '0;
            fl_q    <= '0;
            vld_q   <= 1'b0;
        end else begin
            if (accept) k_len_q <= bus.k_len;
            // Address counter holds at k_len-1, so it can never wrap.
            if (state_q == CLEAR)                 cnt_q <= '0;
            else if (state_q == FEED && !feed_last) cnt_q <= cnt_q + K_W'(1);
            if (state_q == FEED)                  fl_q <= '0;
            else if (state_q == FLUSH)            fl_q <= fl_q + FC_W'(1);
            // Buffer data lands one cycle after the read strobe.
            vld_q <= rd_en_w;
        end
    end

    // ---- diagonal skew: lane i delayed i cycles
    logic [N-1:0][DATA_WIDTH-1:0] left_w, up_w;

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(.DEPTH(i), .DATA_WIDTH(DATA_WIDTH)) u_skew_a (
            .clk    (clk),
            .rst    (rst),
            .data_i (bus.a_col[i]),
            .vld_i  (vld_q),
            .data_o (left_w[i])
        );
        skew_line #(.DEPTH(i), .DATA_WIDTH(DATA_WIDTH)) u_skew_b (
            .clk    (clk),
            .rst    (rst),
            .data_i (bus.b_row[i]),
            .vld_i  (vld_q),
            .data_o (up_w[i])
        );
    end

    assign bus.busy     = busy_w;
    assign bus.done     = done_w;
    assign bus.rd_en    = rd_en_w;
    assign bus.rd_addr  = rd_addr_w;
    assign bus.pe_clr   = pe_clr_w;
    assign bus.left_vec = left_w;
    assign bus.up_vec   = up_w;

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] perf_q;

    // Cleared on acceptance, counts busy cycles, saturates, holds after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             perf_q <= '0;
        else if (accept)                     perf_q <= '0;
        else if (busy_w && (perf_q != '1))   perf_q <= perf_q + 32'd1;
    end

    assign bus.perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
module tb_systolic_ctrl;
    import systolic_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int KW = 8;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_ctrl_if #(.N(N), .DATA_WIDTH(DW), .K_W(KW)) bus ();

    systolic_ctrl #(.N(N), .DATA_WIDTH(DW), .K_W(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---- operand buffer: registered read, garbage when not read
    logic [DW-1:0] a_mem [256][N];
    logic [DW-1:0] b_mem [256][N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.a_col <= '0;
            bus.b_row <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                bus.a_col[i] <= bus.rd_en ? a_mem[bus.rd_addr][i] : DW'($urandom);
                bus.b_row[i] <= bus.rd_en ? b_mem[bus.rd_addr][i] : DW'($urandom);
            end
        end
    end

    // ---- output-stationary PE array
    logic [AW-1:0] acc [N][N];
    logic [DW-1:0] pa  [N][N];
    logic [DW-1:0] pb  [N][N];
    logic          preload = 1'b0;

    always @(posedge clk or posedge rst) begin
        logic [DW-1:0] ain, bin;
        if (rst) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= '0; pa[i][j] <= '0; pb[i][j] <= '0;
                end
        end else if (preload) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) acc[i][j] <= AW'(32'hBAD0 + i * N + j);
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    ain = (j == 0) ? bus.left_vec[i] : pa[i][(j == 0) ? 0 : j - 1];
                    bin = (i == 0) ? bus.up_vec[j]   : pb[(i == 0) ? 0 : i - 1][j];
                    pa[i][j]  <= ain;
                    pb[i][j]  <= bin;
                    acc[i][j] <= bus.pe_clr ? '0 : acc[i][j] + AW'(ain) * AW'(bin);
                end
        end
    end

    // ---- scoreboard
    typedef struct packed {
        logic [N*N-1:0][AW-1:0] sums;
        logic [31:0]            done_cyc;
        logic [31:0]            perf;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t mk_exp(input int k, input int c_now);
        exp_t e;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                logic [AW-1:0] s;
                s = '0;
                for (int kk = 0; kk < k; kk++) s += AW'(a_mem[kk][i]) * AW'(b_mem[kk][j]);
                e.sums[i*N+j] = s;
            end
        e.perf     = (k == 0) ? 32'd1 : 32'(k + 2 * N);
        e.done_cyc = 32'(c_now + 1 + ((k == 0) ? 1 : k + 2 * N));
        return e;
    endfunction

    // ---- monitor
    int   rd_cnt = 0, rd_idx = 0, l3_cnt = 0, l3_cyc = 0, hold_n = 0;
    logic [DW-1:0] l3_val = '0;
    exp_t held;

    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (rst) begin
            rd_idx = 0;
            hold_n = 0;
        end else begin
            if (bus.rd_en) begin
                rd_cnt++;
                chk("rd_addr", 64'(bus.rd_addr), 64'(rd_idx));
                rd_idx++;
            end else begin
                rd_idx = 0;
            end
            if (bus.left_vec[3] != '0) begin
                l3_cnt++;
                l3_cyc = cyc;
                l3_val = bus.left_vec[3];
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cyc", 64'(cyc), 64'(e.done_cyc));
                    chk("busy_at_done", 64'(bus.busy), 64'd0);
                    for (int i = 0; i < N; i++)
                        for (int j = 0; j < N; j++)
                            chk($sformatf("sum_%0d_%0d", i, j), 64'(acc[i][j]), 64'(e.sums[i*N+j]));
`ifdef SYSTOLIC_CTRL_PERF_EN
                    chk("perf_cycles", 64'(bus.perf_cycles), 64'(e.perf));
`endif
                    held   = e;
                    hold_n = 5;
                end
            end else if (hold_n > 0) begin
                if (bus.pe_clr) begin
                    hold_n = 0;
                end else begin
                    ok = 1'b1;
                    for (int i = 0; i < N; i++)
                        for (int j = 0; j < N; j++)
                            if (acc[i][j] !== held.sums[i*N+j]) ok = 1'b0;
                    chk("stable_after_done", 64'(ok), 64'd1);
                    hold_n--;
                end
            end
        end
    end

    // ---- driver helpers (called at a negedge)
    task automatic start_op(input int k, input bit expect_acc, output int clr_cyc);
        bus.k_len = KW'(k);
        bus.start = 1'b1;
        if (expect_acc) sb.push_back(mk_exp(k, cyc));
        @(negedge clk);
        bus.start = 1'b0;
        clr_cyc   = cyc;
        chk("busy_clear", 64'(bus.busy), 64'd1);
        chk("pe_clr_clear", 64'(bus.pe_clr), 64'd1);
    endtask

    task automatic wait_done(input int limit);
        bit seen = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    task automatic fill_rand(input int k);
        for (int kk = 0; kk < k; kk++)
            for (int i = 0; i < N; i++) begin
                a_mem[kk][i] = DW'($urandom);
                b_mem[kk][i] = DW'($urandom);
            end
    endtask

    initial begin
        int c, rd0, l30;
        bus.start = 1'b0;
        bus.k_len = '0;

        // reset state
        @(negedge clk);
        chk("rst_busy",   64'(bus.busy),     64'd0);
        chk("rst_done",   64'(bus.done),     64'd0);
        chk("rst_rd_en",  64'(bus.rd_en),    64'd0);
        chk("rst_rdaddr", 64'(bus.rd_addr),  64'd0);
        chk("rst_pe_clr", 64'(bus.pe_clr),   64'd0);
        chk("rst_left",   64'(bus.left_vec), 64'd0);
        chk("rst_up",     64'(bus.up_vec),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(bus.busy), 64'd0);

        // identity A times B=[1..16]
        for (int kk = 0; kk < N; kk++)
            for (int i = 0; i < N; i++) begin
                a_mem[kk][i] = (i == kk) ? DW'(1) : DW'(0);
                b_mem[kk][i] = DW'(kk * N + i + 1);
            end
        start_op(4, 1'b1, c);
        wait_done(40);
        repeat (6) @(negedge clk);

        // k_len=0 with garbage preloaded in the accumulators
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        rd0 = rd_cnt;
        start_op(0, 1'b1, c);
        wait_done(10);
        chk("k0_rd_en", 64'(rd_cnt - rd0), 64'd0);
        repeat (3) @(negedge clk);

        // k_len=1: lane 3 skew
        for (int i = 0; i < N; i++) begin
            a_mem[0][i] = DW'(i + 2);
            b_mem[0][i] = DW'(1);
        end
        l30 = l3_cnt;
        start_op(1, 1'b1, c);
        wait_done(20);
        chk("l3_count", 64'(l3_cnt - l30), 64'd1);
        chk("l3_cycle", 64'(l3_cyc), 64'(c + 5));
        chk("l3_value", 64'(l3_val), 64'd5);
        repeat (3) @(negedge clk);

        // ignored starts during FEED and FLUSH, then back-to-back start
        fill_rand(4);
        start_op(4, 1'b1, c);
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.k_len = KW'(2);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(30);
        fill_rand(3);
        @(negedge clk);
        start_op(3, 1'b1, c);
        wait_done(30);
        repeat (3) @(negedge clk);

        // reset during FEED cycle 3
        fill_rand(8);
        start_op(8, 1'b0, c);
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy",  64'(bus.busy),     64'd0);
        chk("arst_rd_en", 64'(bus.rd_en),    64'd0);
        chk("arst_left",  64'(bus.left_vec), 64'd0);
        chk("arst_up",    64'(bus.up_vec),   64'd0);
        chk("arst_done",  64'(bus.done),     64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        fill_rand(4);
        start_op(4, 1'b1, c);
        wait_done(30);
        repeat (3) @(negedge clk);

        // maximum k_len
        fill_rand(255);
        start_op(255, 1'b1, c);
        wait_done(300);
        repeat (8) @(negedge clk);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
